// File: rtl/reset_release_sequencer_pkg.sv
// rtl/reset_release_sequencer_pkg.sv - state encodings and sizing helper for the reset release sequencer
package reset_release_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_SWHOLD  = 3'd4
  } seq_state_t;

  // One counter serves both the hold and the stagger phases.
  function automatic int cnt_width(input int hold, input int stagger);
    int m;
    m = (hold > stagger) ? hold : stagger;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_release_sequencer_sync_chain.sv
// rtl/reset_release_sequencer_sync_chain.sv - async-assert, sync-release reset synchronizer
module reset_release_sequencer_sync_chain #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_out
);

  logic [STAGES-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= {q[STAGES-2:0], 1'b1};
    end
  end

  assign sync_out = q[STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// rtl/reset_release_sequencer.sv - staggered reset lane release with software re-reset handshake
module reset_release_sequencer
  import reset_release_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int N_OUT       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_req,
  output logic             sw_ack,
  output logic [N_OUT-1:0] rst_out,
  output logic             ready
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGGER);
  // The SYNC->HOLD step is taken one edge after the chain rises, so the power-on hold loads one less.
  localparam logic [CW-1:0] PON_LOAD     = CW'((HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0);
  localparam logic [CW-1:0] SW_LOAD      = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LOAD = CW'((STAGGER >= 1) ? STAGGER - 1 : 0);
  localparam logic [N_OUT-1:0] FIRST_RELEASE = (STAGGER == 0) ? '0 : ~N_OUT'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (N_OUT < 1 || N_OUT > 16) begin : g_bad_nout
    $error("N_OUT must be in 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (STAGGER < 0) begin : g_bad_stagger
    $error("STAGGER must be >= 0");
  end

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          sw_seq;
  logic          sync_out;

  reset_release_sequencer_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_out (sync_out)
  );

  // Lanes release by shifting zeros in from bit 0, so rst_out == 0 means every lane is out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_SYNC;
      cnt     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      sw_ack  <= 1'b0;
      armed   <= 1'b0;
      sw_seq  <= 1'b0;
    end else begin
      sw_ack <= 1'b0;
      armed  <= armed | ~sw_req;
      case (state)
        ST_SYNC: begin
          if (sync_out) begin
            if (HOLD_CYCLES == 1) begin
              state   <= ST_RELEASE;
              rst_out <= FIRST_RELEASE;
              cnt     <= STAGGER_LOAD;
            end else begin
              state <= ST_HOLD;
              cnt   <= PON_LOAD;
            end
          end
        end
        ST_HOLD, ST_SWHOLD: begin
          if (cnt == '0) begin
            state   <= ST_RELEASE;
            rst_out <= FIRST_RELEASE;
            cnt     <= STAGGER_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (rst_out == '0) begin
            state  <= ST_RUN;
            ready  <= 1'b1;
            sw_ack <= sw_seq;
            sw_seq <= 1'b0;
          end else if (cnt == '0) begin
            rst_out <= rst_out << 1;
            cnt     <= STAGGER_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (sw_req && armed) begin
            state   <= ST_SWHOLD;
            rst_out <= '1;
            ready   <= 1'b0;
            armed   <= 1'b0;
            sw_seq  <= 1'b1;
            cnt     <= SW_LOAD;
          end
        end
        default: begin
          state   <= ST_SYNC;
          rst_out <= '1;
          ready   <= 1'b0;
          cnt     <= '0;
          sw_seq  <= 1'b0;
        end
      endcase
    end
  end

endmodule
